// File: rtl/sum_accumulator.sv
// Accumulates 5-bit operands from the adder stage into an ACC_W-bit running sum.
// Latency: operand accepted at edge k is visible in acc after edge k+1.
// Backpressure: din_ready is high only in IDLE (one operand per two cycles); low once done.
module sum_accumulator #(
  parameter int ACC_W   = 8,
  parameter int MAX_OPS = 8
) (
  input  logic             Clock,
  input  logic             Resetn,
  input  logic [4:0]       din,
  input  logic             din_valid,
  output logic             din_ready,
  input  logic             clr,
  output logic [ACC_W-1:0] acc,
  output logic [3:0]       n_ops,
  output logic             ovf,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] MAX_N = 4'(MAX_OPS);

  state_t           state;
  state_t           state_nxt;
  logic [4:0]       operand;
  logic [ACC_W:0]   sum_ext;

  // Extra top bit of the sum is the carry out of acc, feeding the sticky ovf.
  assign sum_ext   = {1'b0, acc} + {{(ACC_W - 4){1'b0}}, operand};

  // Ready depends only on the registered state, never on din_valid.
  assign din_ready = (state == IDLE);

  // Next-state decode; clr overrides every state.
  always_comb begin
    state_nxt = state;
    if (clr) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (din_valid) state_nxt = ADD;
        ADD:     state_nxt = (n_ops == MAX_N) ? DONE : IDLE;
        DONE:    state_nxt = DONE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // State register plus the registered done flag that mirrors the DONE state.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state <= IDLE;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= (state_nxt == DONE);
    end
  end

  // Datapath: capture operand and count in IDLE, add in ADD, freeze in DONE.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      acc     <= '0;
      n_ops   <= '0;
      ovf     <= 1'b0;
      operand <= '0;
    end else if (clr) begin
      acc     <= '0;
      n_ops   <= '0;
      ovf     <= 1'b0;
      operand <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (din_valid) begin
            operand <= din;
            n_ops   <= n_ops + 4'd1;
          end
        end
        ADD: begin
          acc <= sum_ext[ACC_W-1:0];
          if (sum_ext[ACC_W]) ovf <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sum_accumulator.sv
// Bench for sum_accumulator: two instances (MAX_OPS=8 and MAX_OPS=15) share one stimulus.
// A transaction-level model predicts both; outputs compared 1 time unit after each edge.
// Directed vectors add hand-computed literal checks on top of the model comparison.
module tb_sum_accumulator;

  localparam int ACC_W = 8;
  localparam int MOD   = 1 << ACC_W;

  logic       Clock;
  logic       Resetn;
  logic [4:0] din;
  logic       din_valid;
  logic       clr;

  logic             rdy_a, ovf_a, done_a;
  logic [ACC_W-1:0] acc_a;
  logic [3:0]       n_a;
  logic             rdy_b, ovf_b, done_b;
  logic [ACC_W-1:0] acc_b;
  logic [3:0]       n_b;

  int n_checks = 0;
  int n_fail   = 0;

  sum_accumulator #(.ACC_W(ACC_W), .MAX_OPS(8)) dut_a (
    .Clock(Clock), .Resetn(Resetn), .din(din), .din_valid(din_valid),
    .din_ready(rdy_a), .clr(clr), .acc(acc_a), .n_ops(n_a), .ovf(ovf_a), .done(done_a)
  );

  sum_accumulator #(.ACC_W(ACC_W), .MAX_OPS(15)) dut_b (
    .Clock(Clock), .Resetn(Resetn), .din(din), .din_valid(din_valid),
    .din_ready(rdy_b), .clr(clr), .acc(acc_b), .n_ops(n_b), .ovf(ovf_b), .done(done_b)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: each instance either waits for an operand, holds one pending addition,
  // or is finished. Index 0 is the MAX_OPS=8 instance, index 1 the MAX_OPS=15 one.
  int m_acc [2];
  int m_n   [2];
  int m_op  [2];
  bit m_ovf [2];
  bit m_pend[2];
  bit m_done[2];
  int m_max [2] = '{8, 15};

  always @(posedge Clock or negedge Resetn) begin
    int s;
    for (int i = 0; i < 2; i++) begin
      if (!Resetn || clr) begin
        m_acc[i] <= 0; m_n[i] <= 0; m_op[i] <= 0;
        m_ovf[i] <= 0; m_pend[i] <= 0; m_done[i] <= 0;
      end else if (m_done[i]) begin
        // finished: everything frozen until clr
      end else if (m_pend[i]) begin
        s = m_acc[i] + m_op[i];
        if (s >= MOD) m_ovf[i] <= 1'b1;
        m_acc[i]  <= s % MOD;
        m_pend[i] <= 1'b0;
        m_done[i] <= (m_n[i] == m_max[i]);
      end else if (din_valid) begin
        m_op[i]   <= int'(din);
        m_n[i]    <= m_n[i] + 1;
        m_pend[i] <= 1'b1;
      end
    end
  end

  // Continuous comparison of both instances against the model.
  initial begin
    forever begin
      @(posedge Clock);
      #1;
      check("acc_a",   int'(acc_a),  m_acc[0]);
      check("n_ops_a", int'(n_a),    m_n[0]);
      check("ovf_a",   int'(ovf_a),  int'(m_ovf[0]));
      check("done_a",  int'(done_a), int'(m_done[0]));
      check("ready_a", int'(rdy_a),  int'(!m_pend[0] && !m_done[0]));
      check("acc_b",   int'(acc_b),  m_acc[1]);
      check("n_ops_b", int'(n_b),    m_n[1]);
      check("ovf_b",   int'(ovf_b),  int'(m_ovf[1]));
      check("done_b",  int'(done_b), int'(m_done[1]));
      check("ready_b", int'(rdy_b),  int'(!m_pend[1] && !m_done[1]));
    end
  end

  // Advance one edge; inputs change 2 time units after it, outputs already compared.
  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge Clock);
      #2;
    end
  endtask

  task automatic do_clr();
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
  endtask

  initial begin
    Resetn    = 1'b0;
    din       = '0;
    din_valid = 1'b0;
    clr       = 1'b0;
    tick(3);
    check("rst_acc",   int'(acc_a), 0);
    check("rst_ready", int'(rdy_a), 1);
    check("rst_done",  int'(done_a), 0);
    Resetn = 1'b1;
    tick(1);

    // Single operand 0x13: ready drops for one cycle, sum lands after second edge.
    din = 5'h13; din_valid = 1'b1;
    tick(1);
    din_valid = 1'b0;
    check("first_ready_low", int'(rdy_a), 0);
    check("first_acc_pending", int'(acc_a), 0);
    tick(1);
    check("first_acc", int'(acc_a), 19);
    check("first_n",   int'(n_a), 1);
    check("first_ready_back", int'(rdy_a), 1);

    // Eight operands of 31 back-to-back on the MAX_OPS=8 instance.
    do_clr();
    din = 5'd31; din_valid = 1'b1;
    tick(16);
    check("full_acc",   int'(acc_a), 248);
    check("full_ovf",   int'(ovf_a), 0);
    check("full_done",  int'(done_a), 1);
    check("full_ready", int'(rdy_a), 0);
    tick(4);
    check("ninth_ignored_acc", int'(acc_a), 248);
    check("ninth_ignored_n",   int'(n_a), 8);

    // Wrap and sticky overflow on the MAX_OPS=15 instance.
    do_clr();
    tick(18);
    check("wrap_acc", int'(acc_b), 23);
    check("wrap_ovf", int'(ovf_b), 1);
    check("wrap_n",   int'(n_b), 9);
    tick(2);
    check("sticky_acc", int'(acc_b), 54);
    check("sticky_ovf", int'(ovf_b), 1);
    din_valid = 1'b0;
    tick(2);

    // clr together with a valid operand: operand dropped.
    do_clr();
    din = 5'd7; din_valid = 1'b1; clr = 1'b1;
    tick(1);
    clr = 1'b0; din_valid = 1'b0;
    check("clr_drop_acc",   int'(acc_a), 0);
    check("clr_drop_n",     int'(n_a), 0);
    check("clr_drop_ready", int'(rdy_a), 1);
    tick(1);
    check("clr_drop_acc_later", int'(acc_a), 0);

    // Operand 0 still counts as an operation.
    din = 5'd0; din_valid = 1'b1;
    tick(1);
    din_valid = 1'b0;
    tick(1);
    check("zero_op_n",   int'(n_a), 1);
    check("zero_op_acc", int'(acc_a), 0);

    // Asynchronous reset while an addition of 9 is pending.
    din = 5'd9; din_valid = 1'b1;
    tick(1);
    din_valid = 1'b0;
    tick(1);
    check("pre_rst_acc", int'(acc_a), 9);
    din_valid = 1'b1;
    tick(1);
    din_valid = 1'b0;
    check("pre_rst_n", int'(n_a), 3);
    Resetn = 1'b0;
    #1;
    check("async_rst_acc",   int'(acc_a), 0);
    check("async_rst_n",     int'(n_a), 0);
    check("async_rst_ready", int'(rdy_a), 1);
    check("async_rst_ovf",   int'(ovf_b), 0);
    #2;
    Resetn = 1'b1;
    tick(1);
    check("post_rst_acc", int'(acc_a), 0);

    // Idle with no valid for 20 cycles: nothing moves.
    din = 5'd5; din_valid = 1'b1;
    tick(1);
    din_valid = 1'b0;
    tick(1);
    for (int k = 0; k < 20; k++) begin
      tick(1);
      check("idle_ready", int'(rdy_a), 1);
      check("idle_acc",   int'(acc_a), 5);
      check("idle_n",     int'(n_a), 1);
      check("idle_ovf",   int'(ovf_a), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
